// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// FSM state encodings and the default operand width.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// Single-bit combinational full-adder cell.
// Shared with the ripple adders in the adders library.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first,
// one bit per clock under a start/busy/done handshake.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_cout;
    logic accept;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New requests are taken only when no operation is in flight.
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_RUN: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_PRE) begin
                    cmsb_d = fa_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_d;
                    cout_d  = fa_cout;
                    ovf_d   = cmsb_q ^ fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Subtraction is a + ~b + 1, with the +1 as the initial carry.
        if (accept) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = sub;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=4 and WIDTH=8.
// Drivers push expected results; negedge monitors pop on done.
module tb_serial_addsub;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       cout4, ovf4, busy4, done4;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       cout8, ovf8, busy8, done8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4),
        .a(a4), .b(b4), .sum(sum4), .cout(cout4), .ovf(ovf4),
        .busy(busy4), .done(done4)
    );

    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8),
        .a(a8), .b(b8), .sum(sum8), .cout(cout8), .ovf(ovf8),
        .busy(busy8), .done(done8)
    );

    always @(negedge clk) begin
        if (!rst && done4) begin
            checks++;
            if (busy4) begin
                failures++;
                $display("FAIL w4_busy_done busy=%b done=%b", busy4, done4);
            end
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w4_unexpected_done sum=%h", sum4);
            end else begin
                e4 = q4.pop_front();
                checks++;
                if (sum4 !== e4.sum[3:0] || cout4 !== e4.cout || ovf4 !== e4.ovf) begin
                    failures++;
                    $display("FAIL w4_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             sum4, cout4, ovf4, e4.sum[3:0], e4.cout, e4.ovf);
                end
                checks++;
                if (cyc !== e4.cyc) begin
                    failures++;
                    $display("FAIL w4_latency got cyc=%0d want cyc=%0d", cyc, e4.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done8) begin
            checks++;
            if (busy8) begin
                failures++;
                $display("FAIL w8_busy_done busy=%b done=%b", busy8, done8);
            end
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w8_unexpected_done sum=%h", sum8);
            end else begin
                e8 = q8.pop_front();
                checks++;
                if (sum8 !== e8.sum || cout8 !== e8.cout || ovf8 !== e8.ovf) begin
                    failures++;
                    $display("FAIL w8_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             sum8, cout8, ovf8, e8.sum, e8.cout, e8.ovf);
                end
                checks++;
                if (cyc !== e8.cyc) begin
                    failures++;
                    $display("FAIL w8_latency got cyc=%0d want cyc=%0d", cyc, e8.cyc);
                end
            end
        end
    end

    // Called at a negedge; the next posedge samples start.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s,
                          input logic [3:0] xs, input logic xc, input logic xo);
        exp_t e;
        a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
        e.sum = {4'h0, xs}; e.cout = xc; e.ovf = xo; e.cyc = cyc + 1 + 4;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [7:0] xs, input logic xc, input logic xo);
        exp_t e;
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        e.sum = xs; e.cout = xc; e.ovf = xo; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic check_zero8(input string name);
        checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0 ||
            busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL %s got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
                     name, sum8, cout8, ovf8, busy8, done8);
        end
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        checks++;
        if (sum4 !== 4'h0 || cout4 !== 1'b0 || ovf4 !== 1'b0 ||
            busy4 !== 1'b0 || done4 !== 1'b0) begin
            failures++;
            $display("FAIL w4_reset got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
                     sum4, cout4, ovf4, busy4, done4);
        end
        check_zero8("w8_reset");
        rst = 1'b0;
        @(negedge clk);

        issue4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        repeat (7) @(negedge clk);
        issue4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        repeat (7) @(negedge clk);
        issue4(4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);
        repeat (7) @(negedge clk);

        issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        repeat (11) @(negedge clk);

        // Mid-RUN start must be ignored, then back-to-back from DONE.
        issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL w8_done_timeout got done=0 want done within 20 cycles");
        end else begin
            issue8(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
        end
        repeat (11) @(negedge clk);

        // Reset in the third RUN cycle: outputs cleared, no done.
        issue8(8'h55, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0);
        void'(q8.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero8("w8_mid_run_reset");
        rst = 1'b0;
        repeat (12) @(negedge clk);

        issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        repeat (11) @(negedge clk);

        checks++;
        if (q4.size() != 0) begin
            failures++;
            $display("FAIL w4_pending got %0d outstanding want 0", q4.size());
        end
        checks++;
        if (q8.size() != 0) begin
            failures++;
            $display("FAIL w8_pending got %0d outstanding want 0", q8.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
